// File: rtl/timestamp_tx.sv
// Latches a sec/min/ovf timestamp on request and sends it as a 16-bit serial frame:
// start, 13 data bits LSB first, even parity, stop. Feeds back an ovf-clear pulse.
module timestamp_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       capture,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic       ovf_in,
    output logic       rst_ovf,
    output logic       tx,
    output logic       busy,
    output logic [3:0] drop_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] BAUD_LAST     = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DATA_LAST_IDX = 4'd12;

    logic [2:0]  r_state;
    logic [12:0] r_shift;
    logic        r_parity;
    logic [7:0]  r_baud;
    logic [3:0]  r_bit_idx;
    logic        r_tx;
    logic        r_busy;
    logic        r_rst_ovf;
    logic [3:0]  r_drop_cnt;

    logic        w_idle;
    logic        w_accept;
    logic        w_drop;
    logic        w_bit_end;
    logic [12:0] w_word;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic even_parity(input logic [12:0] v);
        return ^v;
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = capture && w_idle;
    assign w_drop    = capture && !w_idle;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_word    = {ovf_in, sec_in, min_in};

    // Baud counter runs only while a frame is on the wire and reloads at every bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud <= 8'd0;
        end else if (w_idle || w_bit_end) begin
            r_baud <= 8'd0;
        end else begin
            r_baud <= r_baud + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= 13'd0;
            r_parity  <= 1'b0;
            r_bit_idx <= 4'd0;
        end else if (w_accept) begin
            r_shift   <= w_word;
            r_parity  <= even_parity(w_word);
            r_bit_idx <= 4'd0;
        end else if (r_state == S_DATA && w_bit_end) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= (r_bit_idx == DATA_LAST_IDX) ? 4'd0 : r_bit_idx + 4'd1;
        end
    end

    // tx is loaded with the value of the bit being entered, so the pin is glitch-free and registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == DATA_LAST_IDX) begin
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Overflow clear fires once, only for a timestamp that was actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_ovf <= 1'b0;
        end else begin
            r_rst_ovf <= w_accept && ovf_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 4'd0;
        end else if (w_drop) begin
            r_drop_cnt <= sat_inc4(r_drop_cnt);
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign rst_ovf  = r_rst_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_timestamp_tx.sv
// Randomized self-checking bench for timestamp_tx against a frame-level reference model.
module tb_timestamp_tx;

    localparam int CPB = 4;
    localparam int FRAME_CYC = 16 * CPB;

    logic       clk;
    logic       reset;
    logic       capture;
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic       ovf_in;
    logic       rst_ovf;
    logic       tx;
    logic       busy;
    logic [3:0] drop_cnt;

    int n_tests;
    int n_fail;
    int m_drops;

    timestamp_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .sec_in   (sec_in),
        .min_in   (min_in),
        .ovf_in   (ovf_in),
        .rst_ovf  (rst_ovf),
        .tx       (tx),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame as sent on the wire, element 0 first: start, min, sec, ovf, even parity, stop.
    function automatic logic [15:0] mk_frame(input logic [5:0] m, input logic [5:0] s, input logic o);
        logic [12:0] d;
        d = {o, s, m};
        return {1'b1, ^d, d, 1'b0};
    endfunction

    function automatic int sat15(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, tx, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rst_ovf"}, rst_ovf, 1'b0);
        chk({tag, "_drop"}, drop_cnt, m_drops[3:0]);
    endtask

    task automatic idle_cycles(input int n);
        capture = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk_idle("idle");
        end
    endtask

    task automatic arm(input logic [5:0] m, input logic [5:0] s, input logic o);
        min_in  = m;
        sec_in  = s;
        ovf_in  = o;
        capture = 1'b1;
    endtask

    // Call at a negedge with the DUT idle and capture armed; returns at the first idle cycle
    // after the frame (or right after cycle abort_at has been checked).
    task automatic run_frame(input logic [15:0] fr, input logic ov, input bit rnd_in,
                             input bit rnd_cap, input bit hold, input int abort_at);
        logic pc;
        pc = 1'b0;
        @(negedge clk);
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0 && pc) m_drops = sat15(m_drops);
            chk("frame_tx", tx, fr[c / CPB]);
            chk("frame_busy", busy, 1'b1);
            chk("frame_rst_ovf", rst_ovf, (c == 0) ? ov : 1'b0);
            chk("frame_drop", drop_cnt, m_drops[3:0]);
            if (c == abort_at) return;
            if (!hold) capture = rnd_cap ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rnd_in) begin
                sec_in = 6'($urandom);
                min_in = 6'($urandom);
                ovf_in = 1'($urandom);
            end
            pc = capture;
            @(negedge clk);
        end
        if (pc) m_drops = sat15(m_drops);
        chk_idle("post");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_drops = 0;
        chk_idle("rst_async");
        @(negedge clk);
        @(negedge clk);
        chk_idle("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] m, s;
        logic o;
        n_tests = 0;
        n_fail  = 0;
        m_drops = 0;
        reset   = 1'b1;
        capture = 1'b0;
        sec_in  = '0;
        min_in  = '0;
        ovf_in  = 1'b0;

        // Reset idle check
        @(negedge clk);
        do_reset();
        idle_cycles(100);

        // Basic frame with literal expected bit sequence
        arm(6'd5, 6'd42, 1'b0);
        run_frame(16'b1101_0101_0000_1010, 1'b0, 0, 0, 0, -1);
        idle_cycles(3);

        // Overflow consume, max in-range values
        arm(6'd59, 6'd59, 1'b1);
        run_frame(mk_frame(6'd59, 6'd59, 1'b1), 1'b1, 0, 0, 0, -1);
        idle_cycles(2);

        // Out-of-range values pass through unchanged
        arm(6'd63, 6'd63, 1'b0);
        run_frame(mk_frame(6'd63, 6'd63, 1'b0), 1'b0, 0, 0, 0, -1);
        idle_cycles(2);

        // Input stability: inputs scrambled every cycle of the frame
        m = 6'($urandom); s = 6'($urandom); o = 1'($urandom);
        arm(m, s, o);
        run_frame(mk_frame(m, s, o), o, 1, 0, 0, -1);
        idle_cycles(2);

        // Capture held high: three back-to-back frames, one idle cycle apart
        do_reset();
        arm(6'd17, 6'd33, 1'b1);
        run_frame(mk_frame(6'd17, 6'd33, 1'b1), 1'b1, 0, 0, 1, -1);
        run_frame(mk_frame(6'd17, 6'd33, 1'b1), 1'b1, 0, 0, 1, -1);
        run_frame(mk_frame(6'd17, 6'd33, 1'b1), 1'b1, 0, 0, 1, -1);
        chk("drop_saturated", drop_cnt, 4'd15);
        idle_cycles(4);

        // Reset during DATA bit 7, then a clean frame
        do_reset();
        arm(6'd42, 6'd21, 1'b1);
        run_frame(mk_frame(6'd42, 6'd21, 1'b1), 1'b1, 0, 0, 0, 8 * CPB + 1);
        do_reset();
        idle_cycles(2);
        m = 6'($urandom); s = 6'($urandom); o = 1'($urandom);
        arm(m, s, o);
        run_frame(mk_frame(m, s, o), o, 0, 0, 0, -1);
        idle_cycles(2);

        // Randomized frames with random mid-frame captures and random idle gaps
        do_reset();
        for (int k = 0; k < 8; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) idle_cycles(gap);
            m = 6'($urandom); s = 6'($urandom); o = 1'($urandom);
            arm(m, s, o);
            run_frame(mk_frame(m, s, o), o, 1, 1, 0, -1);
        end
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timestamp_tx.md
Name: timestamp_tx

Overview:
- Consumer at the far end of the time counter interface.
- Takes the sec/min/ovf bus and, on a capture request (e.g. a spectrogram frame boundary), latches one timestamp.
- Serialises the timestamp as a 16-bit UART-style frame on one output pin.
- Returns a one-cycle clear pulse to the counter's rst_ovf input when it has consumed a set overflow flag.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (legal range 2..255)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
capture  input  1  request to latch and send current timestamp; sampled each rising edge
sec_in  input  6  seconds from time counter
min_in  input  6  minutes from time counter
ovf_in  input  1  overflow flag from time counter
rst_ovf  output  1  one-cycle pulse, clears counter ovf
tx  output  1  serial data, idle high
busy  output  1  frame in progress
drop_cnt  output  4  captures dropped while busy, saturating

Behaviour:
- Reset (async, immediate, valid mid-frame):
  - tx=1, busy=0, rst_ovf=0, drop_cnt=0.
  - State goes to IDLE; shift register and bit counters cleared.
  - Any frame in progress is abandoned, no stop bit sent.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: capture=1 at an edge while in IDLE.
  - On that edge, latch min_in, sec_in, ovf_in into a 13-bit shift register. Order, LSB first: min[0..5], then sec[0..5], then ovf.
  - Parity = XOR of the 13 latched bits (even parity).
  - Go to START.
  - Outputs from the next cycle: busy=1, tx=0.
- rst_ovf:
  - 1 for exactly the cycle after accept, only if latched ovf=1; otherwise 0.
  - Never asserted for a dropped capture.
- Bit timing: every bit is held exactly CLKS_PER_BIT cycles, using a baud counter 0..CLKS_PER_BIT-1 that reloads at each bit boundary.
- Frame order:
  - START: 1 bit, tx=0.
  - DATA: 13 bits, tx = shift register LSB; shift right at each bit boundary; 4-bit index 0..12.
  - PARITY: 1 bit.
  - STOP: 1 bit, tx=1.
- Frame length: 16*CLKS_PER_BIT cycles, from the first tx=0 cycle to the last STOP cycle inclusive.
- End of frame:
  - After the last STOP cycle, return to IDLE; busy=0 in the following cycle.
  - A capture in that first IDLE cycle is accepted. So with capture held high, frames repeat with exactly 1 idle cycle (tx=1, busy=0) between them.
- Drops:
  - capture=1 in any non-IDLE state is dropped.
  - drop_cnt increments by 1 per dropped edge, saturating at 15.
  - drop_cnt is cleared only by reset.
- Inputs after accept: changes on sec_in/min_in/ovf_in during a frame do not affect it.
- Values: not range-checked; sec_in=63 is transmitted as-is.
- Outputs: all are registered, no combinational paths from inputs.

Test Plan:
- Reset idle check: reset pulse, no capture -> tx=1, busy=0, rst_ovf=0, drop_cnt=0 for 100 cycles.
- Basic frame, CLKS_PER_BIT=4: min=5, sec=42, ovf=0, capture for 1 cycle.
  - tx sequence, 4 cycles per bit: 0 | 1 0 1 0 0 0 | 0 1 0 1 0 1 | 0 | 1 | 1.
  - busy high 64 cycles; rst_ovf stays 0.
- Overflow consume: min=59, sec=59, ovf=1, capture.
  - rst_ovf=1 exactly the cycle after accept.
  - Data bits are 1 1 0 1 1 1 twice, then 1; parity=1.
- Drop count: capture held high for 3 full frames at CLKS_PER_BIT=4.
  - Three frames separated by exactly 1 idle cycle.
  - drop_cnt saturates at 15 during the first frame and holds.
- Reset mid-frame: assert reset during DATA bit 7.
  - tx=1 and busy=0 without waiting for a clock edge.
  - A new capture after release sends a complete correct frame.
- Input stability: change sec_in/min_in every cycle during a frame -> transmitted bits equal the values latched at the accept edge.
